// File: rtl/mm_csr_slave.sv
// ============================================================================
// Module   : mm_csr_slave
// Purpose  : Avalon-MM CSR block for the matmul engine (config, start, done/irq).
// Revision : 1.0
// ============================================================================
`default_nettype none

module mm_csr_slave #(
    parameter int          ADDR_W    = 4,
    parameter logic [15:0] RST_N_VAL = 16'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic              avs_waitrequest,
    output logic [31:0]       cfg_baseA,
    output logic [31:0]       cfg_baseB,
    output logic [31:0]       cfg_baseC,
    output logic [15:0]       cfg_N,
    output logic [15:0]       cfg_lda,
    output logic [15:0]       cfg_ldb,
    output logic [15:0]       cfg_ldc,
    output logic [15:0]       cfg_tilesK,
    output logic              core_start,
    input  logic              core_done,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] c_ADDR_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_ADDR_STATUS = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_BASEA  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_ADDR_BASEB  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_ADDR_BASEC  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_ADDR_DIM    = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] c_ADDR_LDAB   = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] c_ADDR_LDC    = ADDR_W'(7);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_baseA, r_baseB, r_baseC;
    logic [15:0] r_N, r_tilesK, r_lda, r_ldb, r_ldc;
    logic        r_irq_en, r_done, r_err, r_start, r_irq;
    logic [31:0] r_rdata;
    logic        r_rvalid;

    logic [31:0] w_rdata;
    logic [31:0] w_merged;
    logic        w_wr_ctrl, w_w1c, w_start_req, w_accept, w_reject;
    logic        w_cfg_sel, w_cfg_ok, w_cfg_busy, w_done_set, w_err_set;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

    // Current register image; also the base for byte-lane merging on writes.
    always_comb begin
        w_rdata = 32'd0;
        case (avs_address)
            c_ADDR_CTRL:   w_rdata = {29'd0, (r_state == S_BUSY), r_irq_en, 1'b0};
            c_ADDR_STATUS: w_rdata = {30'd0, r_err, r_done};
            c_ADDR_BASEA:  w_rdata = r_baseA;
            c_ADDR_BASEB:  w_rdata = r_baseB;
            c_ADDR_BASEC:  w_rdata = r_baseC;
            c_ADDR_DIM:    w_rdata = {r_tilesK, r_N};
            c_ADDR_LDAB:   w_rdata = {r_ldb, r_lda};
            c_ADDR_LDC:    w_rdata = {16'd0, r_ldc};
            default:       w_rdata = 32'd0;
        endcase
    end

    assign w_merged    = f_merge(w_rdata, avs_writedata, avs_byteenable);
    assign w_wr_ctrl   = avs_write && (avs_address == c_ADDR_CTRL) && avs_byteenable[0];
    assign w_w1c       = avs_write && (avs_address == c_ADDR_STATUS) && avs_byteenable[0];
    assign w_start_req = w_wr_ctrl && avs_writedata[0];
    assign w_accept    = w_start_req && (r_state == S_IDLE) && (r_N != 16'd0);
    assign w_reject    = w_start_req && !w_accept;
    assign w_cfg_sel   = avs_write && (avs_address >= c_ADDR_BASEA) && (avs_address <= c_ADDR_LDC);
    assign w_cfg_ok    = w_cfg_sel && (r_state == S_IDLE);
    assign w_cfg_busy  = w_cfg_sel && (r_state == S_BUSY);
    assign w_done_set  = core_done && (r_state == S_BUSY);
    assign w_err_set   = w_reject || w_cfg_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_baseA  <= 32'd0;
            r_baseB  <= 32'd0;
            r_baseC  <= 32'd0;
            r_N      <= RST_N_VAL;
            r_tilesK <= RST_N_VAL;
            r_lda    <= 16'd0;
            r_ldb    <= 16'd0;
            r_ldc    <= 16'd0;
            r_irq_en <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_start  <= 1'b0;
            r_irq    <= 1'b0;
            r_rdata  <= 32'd0;
            r_rvalid <= 1'b0;
        end else begin
            r_start  <= 1'b0;
            r_rvalid <= avs_read;
            r_irq    <= r_done & r_irq_en;
            if (avs_read) begin
                r_rdata <= w_rdata;
            end

            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_state <= S_BUSY;
                    r_start <= 1'b1;
                end
                S_BUSY: if (core_done) begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Hardware set takes priority over a software clear in the same cycle.
            if (w_done_set) begin
                r_done <= 1'b1;
            end else if (w_w1c && avs_writedata[0]) begin
                r_done <= 1'b0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_w1c && avs_writedata[1]) begin
                r_err <= 1'b0;
            end

            if (w_wr_ctrl) begin
                r_irq_en <= avs_writedata[1];
            end

            if (w_cfg_ok) begin
                case (avs_address)
                    c_ADDR_BASEA: r_baseA <= w_merged;
                    c_ADDR_BASEB: r_baseB <= w_merged;
                    c_ADDR_BASEC: r_baseC <= w_merged;
                    c_ADDR_DIM:   {r_tilesK, r_N} <= w_merged;
                    c_ADDR_LDAB:  {r_ldb, r_lda}  <= w_merged;
                    c_ADDR_LDC:   r_ldc <= w_merged[15:0];
                    default: ;
                endcase
            end
        end
    end

    assign avs_readdata      = r_rdata;
    assign avs_readdatavalid = r_rvalid;
    assign avs_waitrequest   = 1'b0;
    assign cfg_baseA         = r_baseA;
    assign cfg_baseB         = r_baseB;
    assign cfg_baseC         = r_baseC;
    assign cfg_N             = r_N;
    assign cfg_tilesK        = r_tilesK;
    assign cfg_lda           = r_lda;
    assign cfg_ldb           = r_ldb;
    assign cfg_ldc           = r_ldc;
    assign core_start        = r_start;
    assign irq               = r_irq;

endmodule

`default_nettype wire
